// File: rtl/mc_datapath.sv
// mc_datapath: bus datapath with a GPR file, special registers, a single-cycle ALU
// and an iterative signed multiply/divide unit driven by a start/busy/done handshake.
module mc_datapath #(
  parameter int BITS      = 32,
  parameter int REGISTERS = 16,
  parameter int R0_ZERO   = 1
) (
  input  logic                      clk,
  input  logic                      clr,
  input  logic [REGISTERS-1:0]      r_in,
  input  logic [REGISTERS-1:0]      r_out,
  input  logic [5:0]                sp_in,
  input  logic [5:0]                sp_out,
  input  logic                      z_in,
  input  logic [3:0]                alu_op,
  input  logic                      start,
  input  logic                      md_read,
  input  logic [BITS-1:0]           mdata_in,
  output logic [BITS-1:0]           bus,
  output logic [BITS-1:0]           mar_q,
  output logic [BITS*REGISTERS-1:0] gpr_q,
  output logic                      busy,
  output logic                      done,
  output logic                      div0,
  output logic                      bus_err,
  output logic                      bus_err_sticky
);
  localparam int NSRC = REGISTERS + 6;
  localparam int SW   = $clog2(BITS);
  localparam int CW   = $clog2(BITS + 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [3:0] OP_MUL = 4'd10;
  localparam logic [3:0] OP_DIV = 4'd11;

  logic [BITS-1:0]   pc_reg, y_reg, mar_reg, hi_reg, lo_reg, mdr_reg;
  logic [2*BITS-1:0] z_reg;
  logic              sticky_reg;

  logic [1:0]        state_reg;
  logic [CW-1:0]     cnt_reg;
  logic [BITS-1:0]   md_acc_reg, md_sh_reg, md_mag_reg, md_a_reg;
  logic              md_div_reg, md_zdiv_reg, md_negq_reg, md_negr_reg, div0_reg;

  // Bus sources: GPRs first, then sp_out order {MDR, LO, HI, ZHI, ZLO, PC}.
  logic [BITS-1:0] src [NSRC];
  logic [NSRC-1:0] sel;
  logic [BITS-1:0] bus_or;

  assign sel     = {sp_out, r_out};
  assign bus_err = |(sel & (sel - NSRC'(1)));

  always_comb begin
    bus_or = '0;
    for (int i = 0; i < NSRC; i++) begin
      if (sel[i]) bus_or = bus_or | src[i];
    end
  end

  assign bus = bus_err ? '0 : bus_or;

  genvar gi;
  generate
    for (gi = 0; gi < REGISTERS; gi++) begin : g_gpr
      logic [BITS-1:0] q_reg;
      // With R0_ZERO set, R0 keeps its reset value of zero forever.
      always_ff @(posedge clk) begin
        if (!clr) begin
          q_reg <= '0;
        end else if (r_in[gi] && !(R0_ZERO != 0 && gi == 0)) begin
          q_reg <= bus;
        end
      end
      assign src[gi]                = q_reg;
      assign gpr_q[gi*BITS +: BITS] = q_reg;
    end
  endgenerate

  assign src[REGISTERS+0] = pc_reg;
  assign src[REGISTERS+1] = z_reg[BITS-1:0];
  assign src[REGISTERS+2] = z_reg[2*BITS-1:BITS];
  assign src[REGISTERS+3] = hi_reg;
  assign src[REGISTERS+4] = lo_reg;
  assign src[REGISTERS+5] = mdr_reg;

  always_ff @(posedge clk) begin
    if (!clr) begin
      pc_reg     <= '0;
      y_reg      <= '0;
      mar_reg    <= '0;
      hi_reg     <= '0;
      lo_reg     <= '0;
      mdr_reg    <= '0;
      sticky_reg <= 1'b0;
    end else begin
      if (sp_in[0]) pc_reg  <= bus;
      if (sp_in[1]) y_reg   <= bus;
      if (sp_in[2]) mar_reg <= bus;
      if (sp_in[3]) hi_reg  <= bus;
      if (sp_in[4]) lo_reg  <= bus;
      if (sp_in[5]) mdr_reg <= md_read ? mdata_in : bus;
      if (bus_err)  sticky_reg <= 1'b1;
    end
  end

  // Single-cycle ALU: A = Y, B = bus.
  logic [SW-1:0]   shamt;
  logic [BITS-1:0] alu_res;

  assign shamt = bus[SW-1:0];

  always_comb begin
    alu_res = '0;
    case (alu_op)
      4'd0: alu_res = y_reg + bus;
      4'd1: alu_res = y_reg - bus;
      4'd2: alu_res = y_reg & bus;
      4'd3: alu_res = y_reg | bus;
      4'd4: alu_res = y_reg >> shamt;
      4'd5: alu_res = y_reg << shamt;
      4'd6: alu_res = (y_reg >> shamt) | (y_reg << (BITS - int'(shamt)));
      4'd7: alu_res = (y_reg << shamt) | (y_reg >> (BITS - int'(shamt)));
      4'd8: alu_res = -bus;
      4'd9: alu_res = ~bus;
      default: alu_res = '0;
    endcase
  end

  // Multiply/divide step logic on magnitudes; signs are applied when the result is written.
  logic [BITS-1:0]   a_mag, b_mag, div_diff, div_q, div_r;
  logic [BITS:0]     mul_sum, div_sh;
  logic              div_ge, finish;
  logic [2*BITS-1:0] mul_p, mul_res, md_result;

  assign a_mag    = y_reg[BITS-1] ? -y_reg : y_reg;
  assign b_mag    = bus[BITS-1] ? -bus : bus;
  assign mul_sum  = {1'b0, md_acc_reg} + {1'b0, (md_sh_reg[0] ? md_mag_reg : '0)};
  assign div_sh   = {md_acc_reg, md_sh_reg[BITS-1]};
  assign div_ge   = div_sh >= {1'b0, md_mag_reg};
  assign div_diff = BITS'(div_sh - {1'b0, md_mag_reg});
  assign mul_p    = {md_acc_reg, md_sh_reg};
  assign mul_res  = md_negq_reg ? -mul_p : mul_p;
  assign div_q    = md_negq_reg ? -md_sh_reg : md_sh_reg;
  assign div_r    = md_negr_reg ? -md_acc_reg : md_acc_reg;
  assign md_result = md_zdiv_reg ? {md_a_reg, {BITS{1'b1}}} :
                     md_div_reg  ? {div_r, div_q} : mul_res;
  assign finish   = (state_reg == S_RUN) && (md_zdiv_reg || cnt_reg == CW'(BITS));

  always_ff @(posedge clk) begin
    if (!clr) begin
      state_reg   <= S_IDLE;
      cnt_reg     <= '0;
      md_acc_reg  <= '0;
      md_sh_reg   <= '0;
      md_mag_reg  <= '0;
      md_a_reg    <= '0;
      md_div_reg  <= 1'b0;
      md_zdiv_reg <= 1'b0;
      md_negq_reg <= 1'b0;
      md_negr_reg <= 1'b0;
      div0_reg    <= 1'b0;
    end else begin
      case (state_reg)
        S_IDLE: begin
          if (start && (alu_op == OP_MUL || alu_op == OP_DIV)) begin
            md_div_reg  <= (alu_op == OP_DIV);
            md_zdiv_reg <= (alu_op == OP_DIV) && (bus == '0);
            md_a_reg    <= y_reg;
            md_acc_reg  <= '0;
            md_mag_reg  <= (alu_op == OP_DIV) ? b_mag : a_mag;
            md_sh_reg   <= (alu_op == OP_DIV) ? a_mag : b_mag;
            md_negq_reg <= y_reg[BITS-1] ^ bus[BITS-1];
            md_negr_reg <= y_reg[BITS-1];
            cnt_reg     <= '0;
            div0_reg    <= 1'b0;
            state_reg   <= S_RUN;
          end
        end
        S_RUN: begin
          if (finish) begin
            state_reg <= S_DONE;
            if (md_zdiv_reg) div0_reg <= 1'b1;
          end else begin
            cnt_reg <= cnt_reg + CW'(1);
            if (md_div_reg) begin
              md_acc_reg <= div_ge ? div_diff : div_sh[BITS-1:0];
              md_sh_reg  <= {md_sh_reg[BITS-2:0], div_ge};
            end else begin
              md_acc_reg <= mul_sum[BITS:1];
              md_sh_reg  <= {mul_sum[0], md_sh_reg[BITS-1:1]};
            end
          end
        end
        default: state_reg <= S_IDLE;
      endcase
    end
  end

  // The ALU may load Z except while the multiply/divide unit owns it.
  always_ff @(posedge clk) begin
    if (!clr) begin
      z_reg <= '0;
    end else if (finish) begin
      z_reg <= md_result;
    end else if (z_in && state_reg != S_RUN && alu_op != OP_MUL && alu_op != OP_DIV) begin
      z_reg <= {{BITS{1'b0}}, alu_res};
    end
  end

  assign mar_q          = mar_reg;
  assign busy           = (state_reg == S_RUN);
  assign done           = (state_reg == S_DONE);
  assign div0           = div0_reg;
  assign bus_err_sticky = sticky_reg;

endmodule

// File: tb/tb_mc_datapath.sv
// Bench for mc_datapath: vector table for the ALU, directed multi-cycle sequences,
// and random ALU / MUL / DIV traffic checked against an arithmetic reference model.
`timescale 1ns/1ps
module tb_mc_datapath;
  localparam int BITS      = 32;
  localparam int REGISTERS = 16;

  localparam logic [5:0] IN_Y    = 6'b000010;
  localparam logic [5:0] IN_MAR  = 6'b000100;
  localparam logic [5:0] IN_MDR  = 6'b100000;
  localparam logic [5:0] OUT_PC  = 6'b000001;
  localparam logic [5:0] OUT_ZLO = 6'b000010;
  localparam logic [5:0] OUT_ZHI = 6'b000100;
  localparam logic [5:0] OUT_MDR = 6'b100000;

  logic                      clk = 1'b0;
  logic                      clr;
  logic [REGISTERS-1:0]      r_in, r_out;
  logic [5:0]                sp_in, sp_out;
  logic                      z_in, start, md_read;
  logic [3:0]                alu_op;
  logic [BITS-1:0]           mdata_in;
  logic [BITS-1:0]           bus, mar_q;
  logic [BITS*REGISTERS-1:0] gpr_q;
  logic                      busy, done, div0, bus_err, bus_err_sticky;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  mc_datapath #(.BITS(BITS), .REGISTERS(REGISTERS), .R0_ZERO(1)) dut (
    .clk(clk), .clr(clr), .r_in(r_in), .r_out(r_out), .sp_in(sp_in), .sp_out(sp_out),
    .z_in(z_in), .alu_op(alu_op), .start(start), .md_read(md_read), .mdata_in(mdata_in),
    .bus(bus), .mar_q(mar_q), .gpr_q(gpr_q), .busy(busy), .done(done), .div0(div0),
    .bus_err(bus_err), .bus_err_sticky(bus_err_sticky)
  );

  typedef struct {
    string       name;
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
  } alu_vec_t;

  alu_vec_t vecs[11];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%h expected=%h", name, act, exp);
    end else begin
      $display("ok   %s: %h", name, act);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_ctl();
    r_in = '0; r_out = '0; sp_in = '0; sp_out = '0;
    z_in = 1'b0; start = 1'b0; md_read = 1'b0; alu_op = 4'd0;
  endtask

  task automatic put_mdr(input logic [31:0] v);
    mdata_in = v; md_read = 1'b1; sp_in = IN_MDR;
    tick();
    idle_ctl();
  endtask

  task automatic load_y(input logic [31:0] v);
    put_mdr(v);
    sp_out = OUT_MDR; sp_in = IN_Y;
    tick();
    idle_ctl();
  endtask

  task automatic load_gpr(input int idx, input logic [31:0] v);
    put_mdr(v);
    sp_out = OUT_MDR; r_in = REGISTERS'(1) << idx;
    tick();
    idle_ctl();
  endtask

  task automatic read_z(output logic [63:0] z);
    logic [31:0] lo, hi;
    sp_out = OUT_ZLO; #1 lo = bus;
    sp_out = OUT_ZHI; #1 hi = bus;
    sp_out = '0;
    z = {hi, lo};
  endtask

  // Reference ALU using modular arithmetic on wide integers.
  function automatic logic [31:0] ref_alu(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    longint unsigned ua, ub, t, p2;
    int s;
    ua = a; ub = b;
    s  = int'(b % 32);
    p2 = 64'd1 << s;
    case (op)
      4'd0: return 32'(ua + ub);
      4'd1: return 32'(ua + 64'h1_0000_0000 - ub);
      4'd2: return a & b;
      4'd3: return a | b;
      4'd4: return 32'(ua / p2);
      4'd5: return 32'(ua * p2);
      4'd6: begin t = ua * (64'd1 << ((32 - s) % 32)); return 32'(t % 64'h1_0000_0000 + t / 64'h1_0000_0000); end
      4'd7: begin t = ua * p2; return 32'(t % 64'h1_0000_0000 + t / 64'h1_0000_0000); end
      4'd8: return 32'(64'h1_0000_0000 - ub);
      4'd9: return ~b;
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic [63:0] ref_muldiv(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, q, r;
    sa = longint'(signed'(a));
    sb = longint'(signed'(b));
    if (op == 4'd10) return 64'(sa * sb);
    if (b == 32'd0) return {a, 32'hFFFF_FFFF};
    q = sa / sb;
    r = sa % sb;
    return {32'(r), 32'(q)};
  endfunction

  task automatic do_muldiv(input string name, input logic [3:0] op, input logic [31:0] a,
                           input logic [31:0] b, input bit inject);
    logic [63:0] exp_z, z;
    int exp_lat, k, bcnt;
    bit zdiv;
    zdiv    = (op == 4'd11) && (b == 32'd0);
    exp_z   = ref_muldiv(op, a, b);
    exp_lat = zdiv ? 1 : BITS + 1;
    load_y(a);
    put_mdr(b);
    sp_out = OUT_MDR; alu_op = op; start = 1'b1;
    tick();
    start = 1'b0; sp_out = '0;
    bcnt = busy ? 1 : 0;
    k = 0;
    while (!done && k < 200) begin
      // A start while busy carries a zero divisor; accepting it would show up as div0.
      if (inject && k == 3) begin start = 1'b1; alu_op = (op == 4'd10) ? 4'd11 : 4'd10; sp_out = OUT_PC; end
      if (inject && k == 5) begin start = 1'b0; sp_out = '0; end
      tick();
      k++;
      if (busy && !done) bcnt++;
    end
    idle_ctl();
    check({name, "_latency"}, 64'(k), 64'(exp_lat));
    check({name, "_busy_cycles"}, 64'(bcnt), 64'(exp_lat));
    read_z(z);
    check({name, "_z"}, z, exp_z);
    check({name, "_div0"}, 64'(div0), 64'(zdiv));
    sp_out = OUT_MDR; alu_op = 4'd10; start = 1'b1;
    tick();
    idle_ctl();
    check({name, "_start_in_done"}, {62'd0, done, busy}, 64'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: actual=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [63:0] z;
    logic [31:0] a, b, exp32;
    logic [3:0]  op;
    bit seen;

    vecs[0]  = '{"alu_rol",      4'd7,  32'h8000_0001, 32'd4,         32'h0000_0018};
    vecs[1]  = '{"alu_add_wrap", 4'd0,  32'hFFFF_FFFF, 32'd1,         32'h0000_0000};
    vecs[2]  = '{"alu_sub_neg",  4'd1,  32'd0,         32'd1,         32'hFFFF_FFFF};
    vecs[3]  = '{"alu_and",      4'd2,  32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000};
    vecs[4]  = '{"alu_or",       4'd3,  32'hF0F0_F0F0, 32'h0F00_FF00, 32'hFFF0_FFF0};
    vecs[5]  = '{"alu_shr",      4'd4,  32'h8000_0000, 32'd31,        32'h0000_0001};
    vecs[6]  = '{"alu_shl",      4'd5,  32'd3,         32'd2,         32'h0000_000C};
    vecs[7]  = '{"alu_ror",      4'd6,  32'd1,         32'd1,         32'h8000_0000};
    vecs[8]  = '{"alu_neg",      4'd8,  32'h0000_1234, 32'd1,         32'hFFFF_FFFF};
    vecs[9]  = '{"alu_op13",     4'd13, 32'd5,         32'd5,         32'h0000_0000};
    vecs[10] = '{"alu_shamt_lo", 4'd5,  32'd1,         32'h0000_0021, 32'h0000_0002};

    mdata_in = '0;
    idle_ctl();
    clr = 1'b0;
    tick(); tick();
    clr = 1'b1;

    // Reset clears everything that was loaded.
    load_gpr(3, 32'h1234);
    put_mdr(32'h55);
    sp_out = OUT_MDR; sp_in = IN_MAR; tick(); idle_ctl();
    check("r3_loaded", 64'(gpr_q[3*BITS +: BITS]), 64'h1234);
    check("mar_loaded", 64'(mar_q), 64'h55);
    clr = 1'b0; tick(); clr = 1'b1;
    check("rst_gpr_any", 64'(|gpr_q), 64'd0);
    check("rst_mar", 64'(mar_q), 64'd0);
    check("rst_flags", {60'd0, busy, done, div0, bus_err_sticky}, 64'd0);

    // SUB through a GPR on the bus.
    load_y(32'd7);
    load_gpr(1, 32'd5);
    r_out = REGISTERS'(2);
    #1 check("bus_r1", 64'(bus), 64'd5);
    alu_op = 4'd1; z_in = 1'b1;
    tick(); idle_ctl();
    read_z(z);
    check("alu_sub_r1", z, 64'd2);

    foreach (vecs[i]) begin
      load_y(vecs[i].a);
      put_mdr(vecs[i].b);
      sp_out = OUT_MDR; alu_op = vecs[i].op; z_in = 1'b1;
      tick(); idle_ctl();
      read_z(z);
      check(vecs[i].name, z, {32'd0, vecs[i].exp});
    end

    // z_in with a MUL opcode and no start must leave Z alone.
    load_y(32'd9);
    put_mdr(32'd3);
    sp_out = OUT_MDR; alu_op = 4'd10; z_in = 1'b1;
    tick(); idle_ctl();
    read_z(z);
    check("zin_mul_ignored", z, 64'd2);
    check("zin_mul_no_busy", 64'(busy), 64'd0);

    for (int i = 0; i < 30; i++) begin
      op = 4'($urandom_range(0, 12));
      if (op == 4'd9)  op = 4'd14;
      if (op == 4'd10) op = 4'd12;
      if (op == 4'd11) op = 4'd15;
      a = $urandom; b = $urandom;
      exp32 = ref_alu(op, a, b);
      load_y(a);
      put_mdr(b);
      sp_out = OUT_MDR; alu_op = op; z_in = 1'b1;
      tick(); idle_ctl();
      read_z(z);
      check($sformatf("rand_alu%0d_op%0d", i, op), z, {32'd0, exp32});
    end

    do_muldiv("mul_m3x6", 4'd10, 32'hFFFF_FFFD, 32'd6, 1'b1);
    do_muldiv("div_m7by2", 4'd11, 32'hFFFF_FFF9, 32'd2, 1'b0);
    do_muldiv("div_9by0", 4'd11, 32'd9, 32'd0, 1'b0);
    do_muldiv("div_min_by_m1", 4'd11, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    do_muldiv("mul_min_min", 4'd10, 32'h8000_0000, 32'h8000_0000, 1'b0);

    for (int i = 0; i < 14; i++) begin
      op = 4'($urandom_range(10, 11));
      a = $urandom;
      case ($urandom_range(0, 4))
        0: b = 32'd0;
        1: b = $urandom_range(1, 15);
        2: b = -($urandom_range(1, 15));
        default: b = $urandom;
      endcase
      do_muldiv($sformatf("rand_md%0d_op%0d", i, op), op, a, b, 1'b0);
    end

    // Bus contention between R2 and PC.
    load_gpr(2, 32'hDEAD_BEEF);
    r_out = REGISTERS'(4); sp_out = OUT_PC;
    #1;
    check("contend_bus", 64'(bus), 64'd0);
    check("contend_err", 64'(bus_err), 64'd1);
    check("contend_sticky_pre", 64'(bus_err_sticky), 64'd0);
    tick();
    check("contend_sticky_set", 64'(bus_err_sticky), 64'd1);
    idle_ctl();
    tick(); tick(); tick();
    check("contend_err_clear", 64'(bus_err), 64'd0);
    check("contend_sticky_hold", 64'(bus_err_sticky), 64'd1);

    // R0 ignores writes.
    put_mdr(32'hAA);
    sp_out = OUT_MDR; r_in = REGISTERS'(1);
    tick(); idle_ctl();
    check("r0_gpr_q", 64'(gpr_q[BITS-1:0]), 64'd0);
    r_out = REGISTERS'(1);
    #1 check("r0_bus", 64'(bus), 64'd0);
    idle_ctl();

    // Reset in the middle of a multiply.
    load_y(32'd5);
    put_mdr(32'd7);
    sp_out = OUT_MDR; alu_op = 4'd10; start = 1'b1;
    tick(); idle_ctl();
    repeat (10) tick();
    check("midrun_busy", 64'(busy), 64'd1);
    clr = 1'b0; tick(); clr = 1'b1;
    check("midrun_rst_flags", {61'd0, busy, done, div0}, 64'd0);
    seen = 1'b0;
    repeat (40) begin
      tick();
      if (done) seen = 1'b1;
    end
    check("midrun_no_done", 64'(seen), 64'd0);
    read_z(z);
    check("midrun_z", z, 64'd0);
    check("rst_sticky", 64'(bus_err_sticky), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
